// File: rtl/ula_pkg.sv
// Shared opcodes, FSM states and flag bundle for the ula_seq_param ALU.
package ula_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_NOT  = 3'b010;
  localparam logic [2:0] OP_NAND = 3'b011;
  localparam logic [2:0] OP_SOMA = 3'b100;
  localparam logic [2:0] OP_SUB  = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_INV  = 3'b111;

  typedef enum logic {
    ESTADO_OCIOSO     = 1'b0,
    ESTADO_MULTIPLICA = 1'b1
  } estado_t;

  typedef struct packed {
    logic carry;
    logic zero;
    logic negativo;
    logic overflow;
    logic erro;
  } flags_t;

  // Signed overflow of a two's-complement add: same input signs, different result sign.
  function automatic logic ovf_soma(input logic sa, input logic sb, input logic sr);
    return (sa == sb) && (sr != sa);
  endfunction

  function automatic logic ovf_sub(input logic sa, input logic sb, input logic sr);
    return (sa != sb) && (sr != sa);
  endfunction

endpackage

// File: rtl/ula_mult_serial.sv
// Shift-add unsigned multiplier: LARGURA steps after start, done on the last step.
module ula_mult_serial #(
  parameter int LARGURA = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic [LARGURA-1:0]     multiplicando_i,
  input  logic [LARGURA-1:0]     multiplicador_i,
  output logic                   done_o,
  output logic [2*LARGURA-1:0]   produto_o
);

  localparam int CW = $clog2(LARGURA);

  logic [2*LARGURA-1:0] mcand_q;
  logic [2*LARGURA-1:0] prod_q;
  logic [2*LARGURA-1:0] parcela;
  logic [LARGURA-1:0]   mplier_q;
  logic [CW-1:0]        passo_q;
  logic                 ocupado_q;

  assign parcela   = mplier_q[0] ? mcand_q : '0;
  // produto_o already includes the current step, so it is final while done_o is high
  assign produto_o = prod_q + parcela;
  assign done_o    = ocupado_q && (passo_q == CW'(LARGURA - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q   <= '0;
      prod_q    <= '0;
      mplier_q  <= '0;
      passo_q   <= '0;
      ocupado_q <= 1'b0;
    end else if (start_i) begin
      mcand_q   <= {{LARGURA{1'b0}}, multiplicando_i};
      prod_q    <= '0;
      mplier_q  <= multiplicador_i;
      passo_q   <= '0;
      ocupado_q <= 1'b1;
    end else if (ocupado_q) begin
      prod_q   <= produto_o;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      passo_q  <= passo_q + CW'(1);
      if (done_o) ocupado_q <= 1'b0;
    end
  end

endmodule

// File: rtl/ula_seq_param.sv
// Sequential parametrised ALU with valid/ready input, registered flags and serial MUL.
// Optional accumulator operand enabled by defining ULA_ACUMULADOR_EN.
module ula_seq_param
  import ula_pkg::*;
#(
  parameter int LARGURA = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valido_in,
  output logic               pronto_out,
  input  logic [LARGURA-1:0] A,
  input  logic [LARGURA-1:0] B,
  input  logic               carry_in,
  input  logic [2:0]         seletor,
`ifdef ULA_ACUMULADOR_EN
  input  logic               usa_acc,
`endif
  output logic [LARGURA-1:0] resultado,
  output logic               carry_out,
  output logic               zero,
  output logic               negativo,
  output logic               overflow,
  output logic               erro,
  output logic               valido_out
);

  estado_t              estado_q;
  logic [LARGURA-1:0]   res_q, res_d;
  flags_t               flags_q, flags_d;
  logic                 valido_q, pronto_q;
  logic                 aceita, inicia_mul, mul_done;
  logic [LARGURA-1:0]   op_a;
  logic [LARGURA:0]     soma, dif;
  logic [2*LARGURA-1:0] produto;

`ifdef ULA_ACUMULADOR_EN
  logic [LARGURA-1:0] acc_q;
  assign op_a = usa_acc ? acc_q : A;
`else
  assign op_a = A;
`endif

  assign aceita     = valido_in && pronto_q;
  assign inicia_mul = aceita && (seletor == OP_MUL);

  assign soma = {1'b0, op_a} + {1'b0, B} + {{LARGURA{1'b0}}, carry_in};
  // Bit LARGURA of the difference is the unsigned borrow
  assign dif  = {1'b0, op_a} - {1'b0, B} - {{LARGURA{1'b0}}, carry_in};

  ula_mult_serial #(.LARGURA(LARGURA)) u_mult (
    .clk             (clk),
    .rst             (rst),
    .start_i         (inicia_mul),
    .multiplicando_i (op_a),
    .multiplicador_i (B),
    .done_o          (mul_done),
    .produto_o       (produto)
  );

  always_comb begin
    res_d   = '0;
    flags_d = '0;
    if (estado_q == ESTADO_MULTIPLICA) begin
      res_d            = produto[LARGURA-1:0];
      flags_d.overflow = |produto[2*LARGURA-1:LARGURA];
    end else begin
      case (seletor)
        OP_AND:  res_d = op_a & B;
        OP_OR:   res_d = op_a | B;
        OP_NOT:  res_d = ~op_a;
        OP_NAND: res_d = ~(op_a & B);
        OP_SOMA: begin
          res_d            = soma[LARGURA-1:0];
          flags_d.carry    = soma[LARGURA];
          flags_d.overflow = ovf_soma(op_a[LARGURA-1], B[LARGURA-1], soma[LARGURA-1]);
        end
        OP_SUB: begin
          res_d            = dif[LARGURA-1:0];
          flags_d.carry    = dif[LARGURA];
          flags_d.overflow = ovf_sub(op_a[LARGURA-1], B[LARGURA-1], dif[LARGURA-1]);
        end
        OP_MUL:  res_d = '0;
        default: flags_d.erro = 1'b1;
      endcase
    end
    flags_d.zero     = (res_d == '0);
    flags_d.negativo = res_d[LARGURA-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q <= ESTADO_OCIOSO;
      res_q    <= '0;
      flags_q  <= '0;
      valido_q <= 1'b0;
      pronto_q <= 1'b1;
`ifdef ULA_ACUMULADOR_EN
      acc_q    <= '0;
`endif
    end else begin
      valido_q <= 1'b0;
      case (estado_q)
        ESTADO_OCIOSO: begin
          if (aceita) begin
            if (seletor == OP_MUL) begin
              estado_q <= ESTADO_MULTIPLICA;
              pronto_q <= 1'b0;
            end else begin
              res_q    <= res_d;
              flags_q  <= flags_d;
              valido_q <= 1'b1;
`ifdef ULA_ACUMULADOR_EN
              acc_q    <= res_d;
`endif
            end
          end
        end
        ESTADO_MULTIPLICA: begin
          if (mul_done) begin
            res_q    <= res_d;
            flags_q  <= flags_d;
            valido_q <= 1'b1;
            pronto_q <= 1'b1;
            estado_q <= ESTADO_OCIOSO;
`ifdef ULA_ACUMULADOR_EN
            acc_q    <= res_d;
`endif
          end
        end
        default: estado_q <= ESTADO_OCIOSO;
      endcase
    end
  end

  assign resultado  = res_q;
  assign carry_out  = flags_q.carry;
  assign zero       = flags_q.zero;
  assign negativo   = flags_q.negativo;
  assign overflow   = flags_q.overflow;
  assign erro       = flags_q.erro;
  assign valido_out = valido_q;
  assign pronto_out = pronto_q;

endmodule

// File: tb/tb_ula_seq_param.sv
// Scoreboard bench for ula_seq_param (LARGURA=12): directed vectors, random ops, reset abort.
module tb_ula_seq_param;

  localparam int W    = 12;
  localparam int MASK = (1 << W) - 1;
  localparam int SMAX = (1 << (W - 1)) - 1;
  localparam int SMIN = -(1 << (W - 1));

  typedef struct packed {
    logic [W-1:0] res;
    logic         c;
    logic         z;
    logic         n;
    logic         v;
    logic         e;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         valido_in = 1'b0;
  logic         carry_in = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [2:0]   seletor = '0;
  logic         pronto_out, carry_out, zero, negativo, overflow, erro, valido_out;
  logic [W-1:0] resultado;
`ifdef ULA_ACUMULADOR_EN
  logic         usa_acc = 1'b0;
`endif

  ula_seq_param #(.LARGURA(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .valido_in  (valido_in),
    .pronto_out (pronto_out),
    .A          (A),
    .B          (B),
    .carry_in   (carry_in),
    .seletor    (seletor),
`ifdef ULA_ACUMULADOR_EN
    .usa_acc    (usa_acc),
`endif
    .resultado  (resultado),
    .carry_out  (carry_out),
    .zero       (zero),
    .negativo   (negativo),
    .overflow   (overflow),
    .erro       (erro),
    .valido_out (valido_out)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic int sx(input int v);
    return (v > SMAX) ? v - (1 << W) : v;
  endfunction

  // Reference: plain integer arithmetic on the opcode's definition
  function automatic exp_t model(input int op, input int a, input int b, input int c);
    exp_t e;
    int   r, s;
    e = '0;
    r = 0;
    case (op)
      0: r = a & b;
      1: r = a | b;
      2: r = (~a) & MASK;
      3: r = (~(a & b)) & MASK;
      4: begin
        s   = a + b + c;
        r   = s & MASK;
        e.c = (s > MASK);
        s   = sx(a) + sx(b) + c;
        e.v = (s > SMAX) || (s < SMIN);
      end
      5: begin
        s   = a - b - c;
        r   = s & MASK;
        e.c = (s < 0);
        s   = sx(a) - sx(b) - c;
        e.v = (s > SMAX) || (s < SMIN);
      end
      6: begin
        s   = a * b;
        r   = s & MASK;
        e.v = (s > MASK);
      end
      default: e.e = 1'b1;
    endcase
    e.res = W'(r);
    e.z   = (r == 0);
    e.n   = (r >= (1 << (W - 1)));
    return e;
  endfunction

  function automatic exp_t mk(input int r, input bit c, input bit z, input bit n,
                              input bit v, input bit e);
    exp_t x;
    x.res = W'(r);
    x.c = c; x.z = z; x.n = n; x.v = v; x.e = e;
    return x;
  endfunction

  function automatic exp_t got();
    exp_t x;
    x.res = resultado;
    x.c = carry_out; x.z = zero; x.n = negativo; x.v = overflow; x.e = erro;
    return x;
  endfunction

  // Monitor: pops on every valido_out, otherwise checks outputs are held
  initial begin : monitor
    exp_t last, e, g;
    last = '0;
    forever begin
      @(negedge clk);
      g = got();
      if (rst) begin
        last = '0;
      end else if (valido_out) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result got res=%h c=%b z=%b n=%b v=%b e=%b, none expected",
                   g.res, g.c, g.z, g.n, g.v, g.e);
        end else begin
          e = q.pop_front();
          if (g !== e) begin
            errors++;
            $display("FAIL result got res=%h c=%b z=%b n=%b v=%b e=%b exp res=%h c=%b z=%b n=%b v=%b e=%b",
                     g.res, g.c, g.z, g.n, g.v, g.e, e.res, e.c, e.z, e.n, e.v, e.e);
          end
          last = e;
        end
      end else begin
        checks++;
        if (g !== last) begin
          errors++;
          $display("FAIL hold got res=%h flags=%b exp res=%h flags=%b",
                   g.res, {g.c, g.z, g.n, g.v, g.e}, last.res, {last.c, last.z, last.n, last.v, last.e});
        end
      end
    end
  end

  task automatic issue(input int op, input int a, input int b, input int c,
                       input bit dir, input exp_t de);
    int n;
    n = 0;
    @(negedge clk);
    while (!pronto_out && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!pronto_out) begin
      checks++;
      errors++;
      $display("FAIL pronto_timeout got pronto_out=0 exp 1 within 100 cycles");
      return;
    end
    valido_in = 1'b1;
    seletor   = 3'(op);
    A         = W'(a);
    B         = W'(b);
    carry_in  = c[0];
    q.push_back(dir ? de : model(op, a, b, c));
    @(posedge clk);
    #1;
    valido_in = 1'b0;
    A         = W'($urandom);
    B         = W'($urandom);
    carry_in  = 1'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain_timeout got pending=%0d exp 0", q.size());
      q.delete();
    end
  endtask

  initial begin : stim
    int n;
    int op;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (got() !== exp_t'(0) || valido_out !== 1'b0 || pronto_out !== 1'b1) begin
      errors++;
      $display("FAIL reset_values got res=%h flags=%b vo=%b pr=%b exp 0 00000 0 1",
               resultado, {carry_out, zero, negativo, overflow, erro}, valido_out, pronto_out);
    end
    @(negedge clk);
    rst = 1'b0;

    issue(4, 'h0F0, 'h00F, 1, 1, mk('h100, 0, 0, 0, 0, 0));
    issue(5, 'h008, 'h010, 1, 1, mk('hFF7, 1, 0, 1, 0, 0));
    issue(4, 'h7FF, 'h001, 0, 1, mk('h800, 0, 0, 1, 1, 0));
    issue(4, 'hFFF, 'h001, 0, 1, mk('h000, 1, 1, 0, 0, 0));

    // MUL with busy-window measurement and an ignored request mid-operation
    issue(6, 'h012, 'h00A, 0, 1, mk('h0B4, 0, 0, 0, 0, 0));
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (pronto_out) break;
      n++;
      if (n == 3) begin
        valido_in = 1'b1;
        seletor   = 3'b000;
        A         = W'('hFFF);
        B         = W'('hFFF);
      end
      if (n == 4) valido_in = 1'b0;
    end
    checks++;
    if (n != 12) begin
      errors++;
      $display("FAIL mul_busy_cycles got %0d exp 12", n);
    end
    issue(6, 'h100, 'h100, 0, 1, mk('h000, 0, 1, 0, 1, 0));
    drain();

    for (int i = 0; i < 250; i++) begin
      op = int'($urandom_range(0, 7));
      issue(op, int'($urandom_range(0, MASK)), int'($urandom_range(0, MASK)),
            int'($urandom_range(0, 1)), 0, '0);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
    end
    drain();

    issue(7, 'h123, 'h456, 1, 1, mk('h000, 0, 1, 0, 0, 1));
    issue(0, 'hAAA, 'hCCC, 0, 1, mk('h888, 0, 0, 1, 0, 0));
    drain();

    // Reset during cycle 5 of a MUL aborts it with no late result
    issue(6, 'h0FF, 'h0FF, 0, 0, '0);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    q.delete();
    #1;
    checks++;
    if (got() !== exp_t'(0) || valido_out !== 1'b0 || pronto_out !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_mul got res=%h flags=%b vo=%b pr=%b exp 0 00000 0 1",
               resultado, {carry_out, zero, negativo, overflow, erro}, valido_out, pronto_out);
    end
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (valido_out || !pronto_out) n++;
    end
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL post_reset_quiet got %0d bad cycles exp 0", n);
    end

    for (int i = 0; i < 30; i++) begin
      issue(int'($urandom_range(0, 7)), int'($urandom_range(0, MASK)),
            int'($urandom_range(0, MASK)), int'($urandom_range(0, 1)), 0, '0);
    end
    drain();
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ula_seq_param.md
Name: ula_seq_param

Overview:
- Parametrised-width sequential ALU, successor to the 12-bit combinational ALU.
- Adds registered outputs, a valid/ready input handshake and status flags (zero, negative, carry, overflow, error).
- Adds a multi-cycle serial multiply.
- Sits between the operand-select datapath and the result/flag register file.

Parameters:
- LARGURA, 12, operand/result width in bits (min 4).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- valido_in  in  1  operand/opcode valid.
- pronto_out  out  1  block can accept a new operation.
- A  in  LARGURA  operand A.
- B  in  LARGURA  operand B.
- carry_in  in  1  carry-in for ADD, borrow-in for SUB.
- seletor  in  3  opcode.
- resultado  out  LARGURA  registered result.
- carry_out  out  1  carry (ADD) or borrow (SUB).
- zero  out  1  resultado == 0.
- negativo  out  1  resultado[LARGURA-1].
- overflow  out  1  signed overflow (ADD/SUB), or unsigned high-half nonzero (MUL).
- erro  out  1  invalid opcode.
- valido_out  out  1  one-cycle pulse, new result present.

Behaviour:
- Single clock domain. Reset is asynchronous and active-high; the clock and reset ports are clk and rst.
- Reset values: resultado=0, carry_out=0, zero=0, negativo=0, overflow=0, erro=0, valido_out=0, pronto_out=1, FSM=OCIOSO.
- Opcodes:
  - 000 AND; 001 OR; 010 NOT A (B ignored); 011 NAND.
  - 100 ADD: A+B+carry_in.
  - 101 SUB: A-B-carry_in.
  - 110 MUL: unsigned A*B, low LARGURA bits.
  - 111 invalid.
- Handshake: operation accepted on a rising edge where valido_in && pronto_out. Inputs are sampled only at acceptance and may change afterwards.
- FSM states: OCIOSO, MULTIPLICA.
  - OCIOSO, accept, seletor != 110: result and flags registered on the accepting edge; valido_out=1 for the next cycle only; stays in OCIOSO. Latency 1, throughput 1 per cycle.
  - OCIOSO, accept, seletor == 110: load multiplicand, multiplier and 2*LARGURA-bit partial product; go to MULTIPLICA; pronto_out=0.
  - MULTIPLICA: one shift-add step per cycle, step counter 0..LARGURA-1. On step LARGURA-1: register the result, pulse valido_out, return to OCIOSO. pronto_out is low for exactly LARGURA cycles.
  - In the cycle valido_out pulses after a MUL, pronto_out=1, so back-to-back acceptance is allowed.
- valido_in while pronto_out=0: ignored, not queued.
- Outputs hold their last values until the next result is registered. valido_out is the only pulsed output.
- Width rules:
  - ADD is computed LARGURA+1 wide; carry_out = bit LARGURA.
  - SUB: carry_out=1 iff A < B+carry_in (unsigned borrow).
  - Overflow for ADD/SUB is signed two's-complement overflow.
  - Logic ops: carry_out=0, overflow=0.
  - MUL: carry_out=0; overflow=1 iff the upper LARGURA product bits are nonzero.
- Invalid opcode 111: resultado=0, erro=1, zero=1, other flags 0, valido_out pulses. erro clears on the next valid non-111 result.
- Reset asserted mid-MUL: the operation is aborted immediately (asynchronous), with all reset values. Nothing is produced on deassertion.

Optional Feature:
- Macro: ULA_ACUMULADOR_EN.
- Defined:
  - Adds input usa_acc (1 bit) and an internal LARGURA-bit accumulator, reset to 0.
  - When usa_acc=1 at acceptance, the accumulator replaces A as operand.
  - Every registered result, including invalid-opcode results, is written into the accumulator.
- Not defined: the port and the register are absent, and A is always the operand.

Decomposition:
- Package ula_pkg holds:
  - opcode localparams OP_AND, OP_OR, OP_NOT, OP_NAND, OP_SOMA, OP_SUB, OP_MUL, OP_INV;
  - FSM state encoding ESTADO_OCIOSO and ESTADO_MULTIPLICA;
  - a flag-bundle struct/typedef.
- One sub-module, ula_mult_serial: shift-add core with start, step counter and done.

Test Plan (LARGURA=12):
- ADD: A=0x0F0, B=0x00F, carry_in=1 -> one cycle later resultado=0x100, carry_out=0, overflow=0, valido_out pulses 1 cycle.
- SUB with borrow: A=0x008, B=0x010, carry_in=1 -> resultado=0xFF7, carry_out=1, negativo=1.
- ADD boundaries:
  - 0x7FF+0x001 -> 0x800, overflow=1, negativo=1, carry_out=0.
  - 0xFFF+0x001 -> 0x000, zero=1, carry_out=1.
- MUL:
  - 0x012*0x00A -> 0x0B4, with pronto_out low exactly 12 cycles; a valido_in pulse mid-operation is ignored.
  - 0x100*0x100 -> 0x000, overflow=1, zero=1.
- Invalid opcode: seletor=111 -> resultado=0, erro=1, then an AND 0xAAA&0xCCC -> 0x888, erro=0.
- Reset: rst asserted on cycle 5 of a MUL -> all outputs at reset values immediately, pronto_out=1, no valido_out after release.
